// File: rtl/note_scroller_pkg.sv
// Shared constants, lane index type and row-span helper for the note scroller.
package mania_pkg;
    localparam int unsigned ROWS         = 480;
    localparam int unsigned LANES        = 4;
    localparam int unsigned NOTE_H_DEF   = 20;
    localparam int unsigned JUDGE_LO_DEF = 400;
    localparam int unsigned JUDGE_HI_DEF = 439;

    typedef logic [1:0]      lane_idx_t;
    typedef logic [ROWS-1:0] lane_bits_t;

    // Bitmap with rows lo..hi set; used for constant window and clear masks.
    function automatic lane_bits_t row_span(input int unsigned lo, input int unsigned hi);
        lane_bits_t m;
        m = '0;
        for (int unsigned y = 0; y < ROWS; y++) begin
            if (y >= lo && y <= hi) m[y] = 1'b1;
        end
        return m;
    endfunction
endpackage

// File: rtl/note_scroller_if.sv
// Spawn request handshake between the note producer and the scroller.
interface note_scroller_if;
    import mania_pkg::*;

    logic             spawn_valid;
    logic [LANES-1:0] spawn_mask;
    logic             spawn_ready;

    modport master (output spawn_valid, output spawn_mask, input spawn_ready);
    modport slave  (input spawn_valid, input spawn_mask, output spawn_ready);
endinterface

// File: rtl/lane_scroller.sv
// One lane: bitmap shift register, emit counter, key edge detect, hit/miss judging.
module lane_scroller
    import mania_pkg::*;
#(
    parameter int unsigned NOTE_H   = NOTE_H_DEF,
    parameter int unsigned JUDGE_LO = JUDGE_LO_DEF,
    parameter int unsigned JUDGE_HI = JUDGE_HI_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    input  logic       load_i,
    input  logic       key_i,
    output lane_bits_t track_o,
    output logic       idle_o,
    output logic       hit_o,
    output logic       miss_o,
    output logic       hit_pulse_o,
    output logic       miss_pulse_o
);
    localparam int unsigned EW  = $clog2(NOTE_H + 1);
    localparam lane_bits_t  WIN = row_span(JUDGE_LO, JUDGE_HI);
    localparam lane_bits_t  CLR = row_span(JUDGE_LO - NOTE_H + 1, JUDGE_HI);

    lane_bits_t    track_q, track_d, clean;
    logic [EW-1:0] emit_q, emit_d;
    logic [2:0]    sync_q, sync_d;
    logic          hit_pulse_q, miss_pulse_q;
    logic          press;

    always_comb begin
        press  = sync_q[1] & ~sync_q[2];
        hit_o  = press & (|(track_q & WIN));
        // Clear is applied before the shift so a same-cycle hit suppresses the miss.
        clean  = hit_o ? (track_q & ~CLR) : track_q;
        miss_o = step_i & clean[JUDGE_HI] & ~clean[JUDGE_HI+1];
        track_d = step_i ? {clean[ROWS-2:0], (emit_q != '0)} : clean;
        emit_d = emit_q;
        if (load_i) begin
            emit_d = EW'(NOTE_H);
        end else if (step_i && emit_q != '0) begin
            emit_d = emit_q - EW'(1);
        end
        sync_d = {sync_q[1:0], key_i};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            track_q      <= '0;
            emit_q       <= '0;
            sync_q       <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            track_q      <= track_d;
            emit_q       <= emit_d;
            sync_q       <= sync_d;
            hit_pulse_q  <= hit_o;
            miss_pulse_q <= miss_o;
        end
    end

    assign track_o      = track_q;
    assign idle_o       = (emit_q == '0);
    assign hit_pulse_o  = hit_pulse_q;
    assign miss_pulse_o = miss_pulse_q;
endmodule

// File: rtl/note_scroller.sv
// Four-lane note scroller: scroll divider, spawn handshake, score and combo.
module note_scroller
    import mania_pkg::*;
#(
    parameter int unsigned SCROLL_DIV = 250000,
    parameter int unsigned NOTE_H     = NOTE_H_DEF,
    parameter int unsigned JUDGE_LO   = JUDGE_LO_DEF,
    parameter int unsigned JUDGE_HI   = JUDGE_HI_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             key0,
    input  logic             key1,
    input  logic             key2,
    input  logic             key3,
    note_scroller_if.slave   spawn_if,
    output logic [ROWS-1:0]  track0,
    output logic [ROWS-1:0]  track1,
    output logic [ROWS-1:0]  track2,
    output logic [ROWS-1:0]  track3,
    output logic [LANES-1:0] hit_pulse,
    output logic [LANES-1:0] miss_pulse,
    output logic [15:0]      score,
    output logic [11:0]      combo
);
    localparam int unsigned     DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             step, accept;
    logic [LANES-1:0] keys, idle, hit_now, miss_now, load;
    lane_bits_t       track_w [LANES];
    logic [15:0]      score_q, score_d;
    logic [11:0]      combo_q, combo_d;
    logic [2:0]       h;
    logic [16:0]      score_sum;
    logic [12:0]      combo_sum;

    assign keys                 = {key3, key2, key1, key0};
    assign spawn_if.spawn_ready = &idle;
    assign accept               = spawn_if.spawn_valid & spawn_if.spawn_ready;
    assign load                 = accept ? spawn_if.spawn_mask : '0;

    always_comb begin
        step  = run && (div_q == DIV_LAST);
        div_d = div_q;
        if (run) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_scroller #(
            .NOTE_H  (NOTE_H),
            .JUDGE_LO(JUDGE_LO),
            .JUDGE_HI(JUDGE_HI)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .step_i      (step),
            .load_i      (load[i]),
            .key_i       (keys[i]),
            .track_o     (track_w[i]),
            .idle_o      (idle[i]),
            .hit_o       (hit_now[i]),
            .miss_o      (miss_now[i]),
            .hit_pulse_o (hit_pulse[i]),
            .miss_pulse_o(miss_pulse[i])
        );
    end

    // A miss restarts the combo from this cycle's hits rather than from zero.
    always_comb begin
        h = '0;
        for (int unsigned i = 0; i < LANES; i++) h = h + 3'(hit_now[i]);
        score_sum = {1'b0, score_q} + 17'(h);
        score_d   = score_sum[16] ? '1 : score_sum[15:0];
        combo_sum = ((|miss_now) ? 13'd0 : {1'b0, combo_q}) + 13'(h);
        combo_d   = combo_sum[12] ? '1 : combo_sum[11:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q   <= '0;
            score_q <= '0;
            combo_q <= '0;
        end else begin
            div_q   <= div_d;
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign track0 = track_w[0];
    assign track1 = track_w[1];
    assign track2 = track_w[2];
    assign track3 = track_w[3];
    assign score  = score_q;
    assign combo  = combo_q;
endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller with SCROLL_DIV=2, NOTE_H=4, window rows 400..439.
module tb_note_scroller;
    logic clk = 1'b0;
    logic rst, run, key0, key1, key2, key3;
    logic [479:0] track0, track1, track2, track3;
    logic [3:0]   hit_pulse, miss_pulse;
    logic [15:0]  score;
    logic [11:0]  combo;

    note_scroller_if sif ();

    note_scroller #(
        .SCROLL_DIV(2),
        .NOTE_H    (4),
        .JUDGE_LO  (400),
        .JUDGE_HI  (439)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .key0      (key0),
        .key1      (key1),
        .key2      (key2),
        .key3      (key3),
        .spawn_if  (sif.slave),
        .track0    (track0),
        .track1    (track1),
        .track2    (track2),
        .track3    (track3),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .score     (score),
        .combo     (combo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int hit_cnt [4];
    int miss_cnt[4];
    int exp_score = 0;
    int exp_combo = 0;

    typedef struct {
        int   n;
        int   exp_hit;
        int   exp_miss;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [479:0] rows(input int lo, input int hi);
        logic [479:0] r;
        r = '0;
        for (int y = lo; y <= hi; y++) r[y] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_trk(input string name, input logic [479:0] act, input logic [479:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hit_pulse[i])  hit_cnt[i]++;
            if (miss_pulse[i]) miss_cnt[i]++;
        end
    endtask

    // Each call spans 2n edges; starting just after an odd edge, step k lands on its 2k-1'th edge.
    task automatic step_n(input int n);
        for (int i = 0; i < 2 * n; i++) tick();
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 4; i++) begin
            hit_cnt[i]  = 0;
            miss_cnt[i] = 0;
        end
    endtask

    task automatic do_spawn(input logic [3:0] m);
        sif.spawn_valid = 1'b1;
        sif.spawn_mask  = m;
        tick();
        sif.spawn_valid = 1'b0;
        sif.spawn_mask  = '0;
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check_trk({name, "_t0"}, track0, '0);
        check_trk({name, "_t1"}, track1, '0);
        check_trk({name, "_t2"}, track2, '0);
        check_trk({name, "_t3"}, track3, '0);
    endtask

    initial begin
        vecs[0] = '{n: 400, exp_hit: 1, exp_miss: 0};
        vecs[1] = '{n: 420, exp_hit: 1, exp_miss: 0};
        vecs[2] = '{n: 439, exp_hit: 1, exp_miss: 0};
        vecs[3] = '{n: 399, exp_hit: 0, exp_miss: 1};

        rst = 1'b0; run = 1'b1;
        key0 = 1'b0; key1 = 1'b0; key2 = 1'b0; key3 = 1'b0;
        sif.spawn_valid = 1'b0; sif.spawn_mask = '0;
        clear_cnt();
        tick(); tick();
        rst = 1'b1;

        check_all_zero("rst");
        check("rst_score", score, 0);
        check("rst_combo", combo, 0);
        check("rst_ready", sif.spawn_ready, 1);
        check("rst_hit", hit_pulse, 0);
        check("rst_miss", miss_pulse, 0);
        tick();
        step_n(5);
        check_all_zero("idle");
        check("idle_pulses", hit_cnt[0] + miss_cnt[0] + hit_cnt[3] + miss_cnt[3], 0);

        // Empty mask transfers but loads nothing.
        do_spawn(4'b0000);
        check("mask0_ready", sif.spawn_ready, 1);
        step_n(5);
        check_all_zero("mask0");

        // Single note, no key: full flight and one miss.
        clear_cnt();
        do_spawn(4'b0001);
        check("sp_ready_low", sif.spawn_ready, 0);
        step_n(3);
        check("sp_ready_3", sif.spawn_ready, 0);
        step_n(1);
        check("sp_ready_4", sif.spawn_ready, 1);
        check_trk("sp_rows0_3", track0, rows(0, 3));
        check_trk("sp_t1", track1, '0);
        step_n(436);
        check_trk("sp_rows436", track0, rows(436, 439));
        check("sp_nomiss_yet", miss_cnt[0], 0);
        tick();
        check("sp_miss441", miss_pulse, 4'b0001);
        check_trk("sp_rows437", track0, rows(437, 440));
        tick();
        check("sp_miss_once", miss_pulse, 0);
        step_n(50);
        check("sp_miss_cnt", miss_cnt[0], 1);
        check("sp_combo", combo, 0);
        check("sp_score", score, 0);
        check_trk("sp_gone", track0, '0);

        // Four notes hit together near row 410.
        clear_cnt();
        do_spawn(4'b1111);
        step_n(411);
        key0 = 1'b1; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
        step_n(3);
        for (int i = 0; i < 4; i++) check("all_hit", hit_cnt[i], 1);
        exp_score = 4; exp_combo = 4;
        check("all_score", score, exp_score);
        check("all_combo", combo, exp_combo);
        check_all_zero("all_clr");
        key0 = 1'b0; key1 = 1'b0; key2 = 1'b0; key3 = 1'b0;
        step_n(50);
        check("all_nomiss", miss_cnt[0] + miss_cnt[1] + miss_cnt[2] + miss_cnt[3], 0);

        // Key held before the note arrives never re-triggers.
        clear_cnt();
        key0 = 1'b1;
        step_n(2);
        do_spawn(4'b0001);
        step_n(470);
        check("held_nohit", hit_cnt[0], 0);
        check("held_miss", miss_cnt[0], 1);
        exp_combo = 0;
        check("held_combo", combo, exp_combo);
        check("held_score", score, exp_score);
        key0 = 1'b0;
        step_n(5);

        // Press timing against window boundaries; decision edge is step n+2.
        for (int v = 0; v < 4; v++) begin
            clear_cnt();
            do_spawn(4'b0001);
            step_n(vecs[v].n);
            key0 = 1'b1;
            tick(); tick(); tick();
            key0 = 1'b0;
            tick();
            step_n(100);
            check("tbl_hit", hit_cnt[0], vecs[v].exp_hit);
            check("tbl_miss", miss_cnt[0], vecs[v].exp_miss);
            check_trk("tbl_gone", track0, '0);
            if (vecs[v].exp_hit != 0) begin
                exp_score++;
                exp_combo++;
            end
            if (vecs[v].exp_miss != 0) exp_combo = 0;
            check("tbl_score", score, exp_score);
            check("tbl_combo", combo, exp_combo);
        end

        // Freeze scrolling mid-flight, then resume and hit.
        clear_cnt();
        do_spawn(4'b0001);
        step_n(410);
        run = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check_trk("frz_hold", track0, rows(406, 409));
        run = 1'b1;
        tick();
        check_trk("frz_resume", track0, rows(407, 410));
        tick();
        key0 = 1'b1;
        step_n(3);
        check("frz_hit", hit_cnt[0], 1);
        check_trk("frz_clr", track0, '0);
        exp_score++; exp_combo++;
        check("frz_score", score, exp_score);
        check("frz_combo", combo, exp_combo);
        key0 = 1'b0;
        step_n(5);

        // Reset pulse mid-flight with a spawn request pending.
        do_spawn(4'b1111);
        step_n(2);
        check("mid_ready_low", sif.spawn_ready, 0);
        rst = 1'b0;
        sif.spawn_valid = 1'b1;
        sif.spawn_mask  = 4'b1111;
        tick();
        rst = 1'b1;
        sif.spawn_valid = 1'b0;
        sif.spawn_mask  = '0;
        check_all_zero("mid_rst");
        check("mid_score", score, 0);
        check("mid_combo", combo, 0);
        check("mid_ready", sif.spawn_ready, 1);
        check("mid_pulses", {hit_pulse, miss_pulse}, 0);
        step_n(10);
        check_all_zero("mid_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
